// File: rtl/data_mem_responder_if.sv
// Load/store request bundle between the multicycle core (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        Mem_rd;
  logic        Mem_wr;
  logic [31:0] Addr;
  logic [31:0] Wr_data;
  logic [2:0]  F_3;
  logic [31:0] Rd_data;
  logic        Mem_ready;
  logic        Misalign;

  modport master (
    output Mem_rd, Mem_wr, Addr, Wr_data, F_3,
    input  Rd_data, Mem_ready, Misalign
  );

  modport slave (
    input  Mem_rd, Mem_wr, Addr, Wr_data, F_3,
    output Rd_data, Mem_ready, Misalign
  );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I data-memory responder: IDLE->WAIT->ACCESS->RESP, Mem_ready pulses WAIT_CYCLES+2 cycles after accept.
// Optional access counters (Rd_count/Wr_count) are built when DMEM_ACCESS_CNT_EN is defined.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  data_mem_responder_if.slave bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]         Rd_count,
  output logic [15:0]         Wr_count
`endif
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [2:0]        f3_q, f3_d;
  logic              wr_q, wr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              ready_q, ready_d;
  logic              mis_q, mis_d;

  logic [31:0]       mem_q [2**ADDR_W];
  logic [31:0]       rword_q;

  logic [ADDR_W-1:0] widx;
  logic              acc_err;
  logic [31:0]       load_val;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic              mem_we;
  logic              unused_addr;

  // Address bits above the array span wrap, so they are deliberately dropped.
  assign unused_addr = ^bus.Addr[31:ADDR_W+2];
  assign widx        = addr_q[ADDR_W+1:2];

  always_comb begin
    acc_err = 1'b1;
    case (f3_q)
      3'b000:         acc_err = 1'b0;
      3'b001:         acc_err = addr_q[0];
      3'b010:         acc_err = |addr_q[1:0];
      3'b100, 3'b101: acc_err = wr_q | (f3_q[0] & addr_q[0]);
      default:        acc_err = 1'b1;
    endcase
  end

  assign byte_sel = rword_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? rword_q[31:16] : rword_q[15:0];

  always_comb begin
    load_val = rword_q;
    case (f3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = rword_q;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the lane(s) that land.
  always_comb begin
    be    = 4'b1111;
    wlane = wdat_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdat_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdat_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdat_q;
      end
    endcase
  end

  assign mem_we = (state_q == S_ACCESS) && wr_q && !acc_err;

  always_ff @(posedge Clk) begin
    if (state_q == S_ACCESS) begin
      rword_q <= mem_q[widx];
    end
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) begin
        mem_q[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    f3_d      = f3_q;
    wr_d      = wr_q;
    rd_data_d = rd_data_q;
    ready_d   = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Mem_rd || bus.Mem_wr) begin
          addr_d  = bus.Addr[ADDR_W+1:0];
          wdat_d  = bus.Wr_data;
          f3_d    = bus.F_3;
          wr_d    = bus.Mem_wr;
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        ready_d = 1'b1;
        mis_d   = acc_err;
        if (acc_err) begin
          rd_data_d = 32'd0;
        end else if (!wr_q) begin
          rd_data_d = load_val;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdat_q    <= 32'd0;
      f3_q      <= 3'd0;
      wr_q      <= 1'b0;
      rd_data_q <= 32'd0;
      ready_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      f3_q      <= f3_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.Rd_data   = rd_data_q;
  assign bus.Mem_ready = ready_q;
  assign bus.Misalign  = mis_q;

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if ((state_q == S_RESP) && !acc_err) begin
      if (wr_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign Rd_count = rd_cnt_q;
  assign Wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a byte-level memory model.
module tb_data_mem_responder;
  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam int LAT         = WAIT_CYCLES + 2;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] er;
    bit          em;
  } op_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  data_mem_responder_if bus ();
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] Rd_count;
  logic [15:0] Wr_count;
`endif

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .Rd_count(Rd_count),
    .Wr_count(Wr_count)
`endif
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rd     = 32'd0;
  int          exp_rd_cnt = 0;
  int          exp_wr_cnt = 0;

  // Reference: legality from size/alignment, byte-lane update, shift-and-extend loads.
  task automatic model_op(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, output bit mis);
    int          size;
    int          idx;
    int          off;
    bit          legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((a % size) != 0) legal = 1'b0;
    idx = int'((a / 4) % DEPTH);
    off = int'(a % 4);
    mis = !legal;
    if (!legal) begin
      exp_rd = 32'd0;
    end else if (wr) begin
      for (int k = 0; k < size; k++) model_mem[idx][8*(off+k) +: 8] = wd[8*k +: 8];
      if (exp_wr_cnt < 65535) exp_wr_cnt++;
    end else begin
      v = model_mem[idx] >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      exp_rd = v;
      if (exp_rd_cnt < 65535) exp_rd_cnt++;
    end
  endtask

  // Drives one request, scrambles the inputs while waiting, and drops it in the ready cycle.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3, output int lat, output logic [31:0] rdat,
                           output logic mis);
    @(negedge Clk);
    bus.Mem_rd = rd; bus.Mem_wr = wr; bus.Addr = a; bus.Wr_data = wd; bus.F_3 = f3;
    @(posedge Clk);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk);
      #1;
      if (bus.Mem_ready) begin
        lat = c;
        break;
      end
      bus.Addr = $urandom; bus.Wr_data = $urandom; bus.F_3 = 3'($urandom_range(0, 7));
    end
    bus.Mem_rd = 1'b0; bus.Mem_wr = 1'b0;
    rdat = bus.Rd_data;
    mis  = bus.Misalign;
    tests_run++;
    if (lat < 0) begin
      tests_failed++;
      $display("FAIL timeout addr=%h: no Mem_ready within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    bus.Mem_rd = 1'b0; bus.Mem_wr = 1'b0; bus.Addr = 32'd0; bus.Wr_data = 32'd0; bus.F_3 = 3'd0;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    tests_run += 3;
    if (bus.Mem_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0", bus.Mem_ready); end
    if (bus.Rd_data !== 32'd0) begin tests_failed++; $display("FAIL reset_rd got=%h exp=0", bus.Rd_data); end
    if (bus.Misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_mis got=%b exp=0", bus.Misalign); end
    @(negedge Clk);
    Rst = 1'b0;
    exp_rd = 32'd0; exp_rd_cnt = 0; exp_wr_cnt = 0;
  endtask

  task automatic test_directed();
    op_t tbl [13] = '{
      '{1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0},
      '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0},
      '{1'b0, 32'h13,   32'h0,        3'b000, 32'hFFFFFFDE, 1'b0},
      '{1'b0, 32'h13,   32'h0,        3'b100, 32'h000000DE, 1'b0},
      '{1'b0, 32'h12,   32'h0,        3'b001, 32'hFFFFDEAD, 1'b0},
      '{1'b0, 32'h10,   32'h0,        3'b101, 32'h0000BEEF, 1'b0},
      '{1'b1, 32'h11,   32'h00000055, 3'b000, 32'h0000BEEF, 1'b0},
      '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0},
      '{1'b1, 32'h11,   32'h00001234, 3'b001, 32'h00000000, 1'b1},
      '{1'b0, 32'h12,   32'h0,        3'b010, 32'h00000000, 1'b1},
      '{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0},
      '{1'b1, 32'h1010, 32'h0BADF00D, 3'b010, 32'hDEAD55EF, 1'b0},
      '{1'b0, 32'h10,   32'h0,        3'b010, 32'h0BADF00D, 1'b0}
    };
    int          lat;
    logic [31:0] rdat;
    logic        mis;
    bit          mmis;
    for (int i = 0; i < 13; i++) begin
      do_access(tbl[i].wr, !tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, lat, rdat, mis);
      model_op(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, mmis);
      tests_run += 3;
      if (lat != LAT) begin tests_failed++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      if (rdat !== tbl[i].er) begin tests_failed++; $display("FAIL dir%0d_rdata got=%h exp=%h", i, rdat, tbl[i].er); end
      if (mis !== tbl[i].em) begin tests_failed++; $display("FAIL dir%0d_misalign got=%b exp=%b", i, mis, tbl[i].em); end
      if (i == 0) begin
        @(posedge Clk);
        #1;
        tests_run++;
        if (bus.Mem_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_pulse_width got=%b exp=0", bus.Mem_ready); end
      end
    end
`ifdef DMEM_ACCESS_CNT_EN
    tests_run += 2;
    if (Rd_count !== 16'(exp_rd_cnt)) begin tests_failed++; $display("FAIL dir_rd_count got=%0d exp=%0d", Rd_count, exp_rd_cnt); end
    if (Wr_count !== 16'(exp_wr_cnt)) begin tests_failed++; $display("FAIL dir_wr_count got=%0d exp=%0d", Wr_count, exp_wr_cnt); end
`endif
  endtask

  task automatic test_reset_abort();
    int          lat;
    logic [31:0] rdat;
    logic        mis;
    bit          mmis;
    bit          seen;
    do_access(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 3'b010, lat, rdat, mis);
    model_op(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, mmis);
    @(negedge Clk);
    bus.Mem_wr = 1'b1; bus.Mem_rd = 1'b0; bus.Addr = 32'h20; bus.Wr_data = 32'h12345678; bus.F_3 = 3'b010;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    bus.Mem_wr = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    exp_rd = 32'd0; exp_rd_cnt = 0; exp_wr_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk);
      #1;
      if (bus.Mem_ready) seen = 1'b1;
    end
    tests_run += 2;
    if (seen) begin tests_failed++; $display("FAIL abort_no_ready got=1 exp=0"); end
    if (bus.Rd_data !== 32'd0) begin tests_failed++; $display("FAIL abort_rd_cleared got=%h exp=0", bus.Rd_data); end
    do_access(1'b0, 1'b1, 32'h20, 32'h0, 3'b010, lat, rdat, mis);
    model_op(1'b0, 32'h20, 32'h0, 3'b010, mmis);
    tests_run += 2;
    if (rdat !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL abort_word_kept got=%h exp=cafef00d", rdat); end
    if (lat != LAT) begin tests_failed++; $display("FAIL abort_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_both_req();
    int          lat;
    logic [31:0] rdat;
    logic        mis;
    bit          mmis;
    do_access(1'b1, 1'b1, 32'h30, 32'hA5A55A5A, 3'b010, lat, rdat, mis);
    model_op(1'b1, 32'h30, 32'hA5A55A5A, 3'b010, mmis);
    tests_run++;
    if (rdat !== exp_rd) begin tests_failed++; $display("FAIL both_store_holds_rd got=%h exp=%h", rdat, exp_rd); end
    do_access(1'b0, 1'b1, 32'h30, 32'h0, 3'b010, lat, rdat, mis);
    model_op(1'b0, 32'h30, 32'h0, 3'b010, mmis);
    tests_run++;
    if (rdat !== 32'hA5A55A5A) begin tests_failed++; $display("FAIL both_is_store got=%h exp=a5a55a5a", rdat); end
  endtask

  // Request left high through the ready cycle is taken as a second, back-to-back request.
  task automatic test_back_to_back();
    int  lat2;
    bit  mmis;
    bit  got1;
    @(negedge Clk);
    bus.Mem_rd = 1'b1; bus.Mem_wr = 1'b0; bus.Addr = 32'h30; bus.F_3 = 3'b000; bus.Wr_data = 32'h0;
    got1 = 1'b0;
    for (int c = 0; c < 20 && !got1; c++) begin
      @(posedge Clk);
      #1;
      got1 = bus.Mem_ready;
    end
    model_op(1'b0, 32'h30, 32'h0, 3'b000, mmis);
    @(posedge Clk);
    lat2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk);
      #1;
      if (bus.Mem_ready) begin
        lat2 = c;
        break;
      end
    end
    bus.Mem_rd = 1'b0;
    model_op(1'b0, 32'h30, 32'h0, 3'b000, mmis);
    tests_run += 3;
    if (!got1) begin tests_failed++; $display("FAIL b2b_first got=0 exp=1"); end
    if (lat2 != LAT) begin tests_failed++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, LAT); end
    if (bus.Rd_data !== exp_rd) begin tests_failed++; $display("FAIL b2b_rdata got=%h exp=%h", bus.Rd_data, exp_rd); end
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] rdat;
    logic        mis;
    bit          mmis;
    bit          wr;
    bit          rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      do_access(1'b1, 1'b0, 32'(w * 4), wd, 3'b010, lat, rdat, mis);
      model_op(1'b1, 32'(w * 4), wd, 3'b010, mmis);
    end
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      wd = $urandom;
      do_access(wr, rd, a, wd, f3, lat, rdat, mis);
      model_op(wr, a, wd, f3, mmis);
      tests_run += 3;
      if (lat != LAT) begin tests_failed++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, LAT); end
      if (rdat !== exp_rd) begin tests_failed++; $display("FAIL rnd%0d_rdata wr=%0d f3=%0d a=%h got=%h exp=%h", n, wr, f3, a, rdat, exp_rd); end
      if (mis !== mmis) begin tests_failed++; $display("FAIL rnd%0d_misalign f3=%0d a=%h got=%b exp=%b", n, f3, a, mis, mmis); end
    end
`ifdef DMEM_ACCESS_CNT_EN
    tests_run += 2;
    if (Rd_count !== 16'(exp_rd_cnt)) begin tests_failed++; $display("FAIL rnd_rd_count got=%0d exp=%0d", Rd_count, exp_rd_cnt); end
    if (Wr_count !== 16'(exp_wr_cnt)) begin tests_failed++; $display("FAIL rnd_wr_count got=%0d exp=%0d", Wr_count, exp_wr_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_both_req();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface: accepts load/store requests from the multicycle core, services them after a programmable wait, returns a one-cycle ready pulse.
- Replaces the single-cycle data memory behind the core's memory-request signals (Mem_rd/Mem_wr, address, store data).
- Adds RV32I byte/halfword/word sizing, load sign/zero extension and misalignment detection.

Parameters:
- ADDR_W, 10, word-address bits; memory depth 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra wait-state cycles before the array access; legal range 0..15.

Ports:
- Clk  input  1  clock; all state updates on its rising edge.
- Rst  input  1  asynchronous reset, active-high.
- Mem_rd  input  1  load request.
- Mem_wr  input  1  store request.
- Addr  input  32  byte address.
- Wr_data  input  32  store data; uses the low byte/half for sb/sh.
- F_3  input  3  RV32I funct3 giving access size and signedness.
- Rd_data  output  32  extended load result.
- Mem_ready  output  1  one-cycle completion pulse.
- Misalign  output  1  error flag; valid only while Mem_ready=1.

Behaviour:
- Reset (async, Rst=1): state IDLE, Rd_data=0, Mem_ready=0, Misalign=0, wait counter=0. Array contents are not cleared.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: at a rising edge with Mem_rd|Mem_wr=1, latch Addr, Wr_data, F_3 and request type. Go to WAIT, or to ACCESS if WAIT_CYCLES=0.
- Simultaneous Mem_rd and Mem_wr: the request is a store.
- WAIT: counter counts up to WAIT_CYCLES, then goes to ACCESS. Input changes are ignored after the request is latched.
- ACCESS: performs the array read or write, then goes to RESP.
- RESP: Mem_ready=1 for exactly one cycle, then IDLE.
- Latency: Mem_ready rises WAIT_CYCLES+2 cycles after the accept edge. The minimum, with WAIT_CYCLES=0, is 2.
- Initiator rule: hold the request until Mem_ready, and deassert it in the Mem_ready cycle. A request still high in the following IDLE cycle is accepted as a new request.
- Word index is Addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2^ADDR_W.
- Loads:
  - 000 lb: sign-extend the byte selected by Addr[1:0].
  - 001 lh: sign-extend the half selected by Addr[1].
  - 010 lw: full word.
  - 100 lbu, 101 lhu: zero-extend.
- Stores:
  - 000 sb: update only the addressed byte lane.
  - 001 sh: update only the addressed half.
  - 010 sw: update the full word.
- Error cases:
  - Halfword access with Addr[0]=1.
  - Word access with Addr[1:0]!=0.
  - Any F_3 not listed above (011, 110, 111, and store F_3 of 1xx).
- On an error: no array write, Rd_data forced to 0, Misalign=1 with Mem_ready.
- Rd_data updates only in the load RESP cycle and holds until the next load completes. Stores leave Rd_data unchanged.
- Reset asserted mid-operation aborts the access. A store aborted before ACCESS does not write; no Mem_ready is issued.

Optional Feature:
- Macro DMEM_ACCESS_CNT_EN.
- Defined:
  - Adds output ports Rd_count [15:0] and Wr_count [15:0].
  - Each increments in the RESP cycle of a successful load or store.
  - Error accesses are not counted.
  - Counters saturate at 16'hFFFF and reset to 0 on Rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- WAIT_CYCLES=2. sw 32'hDEADBEEF at Addr 0x10, then lw 0x10 -> Mem_ready exactly 4 cycles after each accept edge; Rd_data=32'hDEADBEEF; Misalign=0.
- Same word holds 32'hDEADBEEF:
  - lb 0x13 -> 32'hFFFFFFDE.
  - lbu 0x13 -> 32'h000000DE.
  - lh 0x12 -> 32'hFFFFDEAD.
  - lhu 0x10 -> 32'h0000BEEF.
- sb 32'h00000055 at Addr 0x11 over 32'hDEADBEEF, then lw 0x10 -> 32'hDEAD55EF.
- sh at Addr 0x11 and lw at Addr 0x12 -> Misalign=1 with Mem_ready, Rd_data=0; subsequent lw 0x10 shows the word unchanged.
- Reset cases:
  - Rst pulsed during WAIT of sw 0x20 data 32'h12345678 -> no Mem_ready; lw 0x20 returns the prior contents.
  - Mem_rd and Mem_wr high together -> a store is performed.
- With DMEM_ACCESS_CNT_EN and ADDR_W=10:
  - 3 good loads, 2 good stores, 1 misaligned load -> Rd_count=3, Wr_count=2.
  - sw at Addr 0x1010 writes word index 4; lw 0x10 returns that data.
